// File: rtl/hw_ov7670_capture_pkg.sv
// Shared types and defaults for the OV7670 frame grabber.
package hw_ov7670_capture_pkg;

  localparam int unsigned HW_OV7670_DWIDTH    = 8;
  localparam int unsigned HW_OV7670_PIX_WIDTH = 16;
  localparam int unsigned DEF_IMG_W           = 640;
  localparam int unsigned DEF_IMG_H           = 480;
  localparam int unsigned DEF_AWIDTH          = 20;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_WAIT_VS,
    ST_WAIT_FS,
    ST_CAPTURE,
    ST_PUBLISH
  } cap_state_e;

  // One RGB565 pixel as it arrives from the sensor: first byte in the upper half.
  typedef struct packed {
    logic [HW_OV7670_DWIDTH-1:0] hi;
    logic [HW_OV7670_DWIDTH-1:0] lo;
  } pix_t;

  function automatic logic [7:0] sat_inc8(input logic [7:0] v);
    return (v == 8'hFF) ? v : v + 8'd1;
  endfunction

endpackage

// File: rtl/hw_ov7670_sync_edge.sv
// Two-flop synchroniser for one asynchronous camera signal, with rise/fall strobes.
module hw_ov7670_sync_edge (
  input  logic aclk,
  input  logic areset,
  input  logic d,
  output logic q,
  output logic rise_c,
  output logic fall_c
);

  logic s1, s2, s3;

  always_ff @(posedge aclk or posedge areset) begin
    if (areset) begin
      s1 <= 1'b0;
      s2 <= 1'b0;
      s3 <= 1'b0;
    end else begin
      s1 <= d;
      s2 <= s1;
      s3 <= s2;
    end
  end

  assign q      = s2;
  assign rise_c = s2 & ~s3;
  assign fall_c = ~s2 & s3;

endmodule

// File: rtl/hw_ov7670_capture.sv
// OV7670 frame grabber: oversampled camera bus -> 16-bit pixels -> ping-pong BRAM frames.
// Optional test-pattern source enabled by defining HW_OV7670_TPG_EN (adds tpg_sel).
module hw_ov7670_capture
  import hw_ov7670_capture_pkg::*;
#(
  parameter int unsigned IMG_W      = DEF_IMG_W,
  parameter int unsigned IMG_H      = DEF_IMG_H,
  parameter int unsigned NUM_BUF    = 2,
  parameter int unsigned AWIDTH     = DEF_AWIDTH,
  parameter int unsigned XCLK_DIV   = 4,
  parameter int unsigned RST_CYCLES = 1024
) (
  input  logic                           aclk,
  input  logic                           areset,
  input  logic                           enable,
  input  logic                           rd_lock,
  output logic                           rd_idx,
  output logic                           frame_done,
  output logic                           frame_err,
  output logic [7:0]                     drop_cnt,
  output logic [AWIDTH-1:0]              bram_addr,
  output logic [HW_OV7670_PIX_WIDTH-1:0] bram_din,
  output logic                           bram_en,
  output logic                           bram_we,
  input  logic                           cam_pclk,
  input  logic                           cam_href,
  input  logic                           cam_vsync,
  input  logic [HW_OV7670_DWIDTH-1:0]    cam_d,
  output logic                           cam_rst_n,
  output logic                           cam_xclk
`ifdef HW_OV7670_TPG_EN
  ,
  input  logic                           tpg_sel
`endif
);

  localparam int unsigned FRAME_PIX = IMG_W * IMG_H;
  localparam int unsigned XW        = $clog2(IMG_W + 2);
  localparam int unsigned YW        = $clog2(IMG_H + 2);
  localparam int unsigned HALF      = XCLK_DIV / 2;
  localparam int unsigned XCW       = $clog2(HALF + 1);
  localparam int unsigned RCW       = $clog2(RST_CYCLES + 1);

  logic pclk_rise_c, pclk_unused_q, pclk_unused_fall;
  logic href_s, href_unused_rise, href_unused_fall;
  logic vsync_s, vsync_rise_c, vsync_fall_c;
  logic [HW_OV7670_DWIDTH-1:0] d_s1, d_s2;

  hw_ov7670_sync_edge u_sync_pclk (
    .aclk(aclk), .areset(areset), .d(cam_pclk),
    .q(pclk_unused_q), .rise_c(pclk_rise_c), .fall_c(pclk_unused_fall)
  );
  hw_ov7670_sync_edge u_sync_href (
    .aclk(aclk), .areset(areset), .d(cam_href),
    .q(href_s), .rise_c(href_unused_rise), .fall_c(href_unused_fall)
  );
  hw_ov7670_sync_edge u_sync_vsync (
    .aclk(aclk), .areset(areset), .d(cam_vsync),
    .q(vsync_s), .rise_c(vsync_rise_c), .fall_c(vsync_fall_c)
  );

  // Data bus synchronised with the same latency as PCLK so it lines up with pclk_rise_c.
  always_ff @(posedge aclk or posedge areset) begin
    if (areset) begin
      d_s1 <= '0;
      d_s2 <= '0;
    end else begin
      d_s1 <= cam_d;
      d_s2 <= d_s1;
    end
  end

  // Sensor clock and power-on reset sequencing.
  logic [XCW-1:0] xcnt;
  logic [RCW-1:0] rst_cnt;

  always_ff @(posedge aclk or posedge areset) begin
    if (areset) begin
      xcnt      <= '0;
      cam_xclk  <= 1'b0;
      rst_cnt   <= '0;
      cam_rst_n <= 1'b0;
    end else begin
      if (xcnt == '0) cam_xclk <= ~cam_xclk;
      xcnt <= (xcnt == XCW'(HALF - 1)) ? '0 : xcnt + XCW'(1);
      if (!cam_rst_n) begin
        if (rst_cnt == RCW'(RST_CYCLES - 1)) cam_rst_n <= 1'b1;
        else rst_cnt <= rst_cnt + RCW'(1);
      end
    end
  end

  cap_state_e                  state;
  logic                        enable_q, wr_buf, skip, bad, phase, href_q;
  logic [HW_OV7670_DWIDTH-1:0] byte0;
  logic [XW-1:0]               x;
  logic [YW-1:0]               y;
  logic [AWIDTH-1:0]           line_base;
  logic                        next_buf_c;
  pix_t                        pix_c;

  assign next_buf_c = (NUM_BUF > 1) ? ~wr_buf : 1'b0;

`ifdef HW_OV7670_TPG_EN
  assign pix_c = tpg_sel ? '{hi: 8'(x), lo: 8'(y)} : '{hi: byte0, lo: d_s2};
`else
  assign pix_c = '{hi: byte0, lo: d_s2};
`endif

  // Capture FSM; a frame that starts outside WAIT_FS is never entered.
  always_ff @(posedge aclk or posedge areset) begin
    if (areset) begin
      state      <= ST_IDLE;
      enable_q   <= 1'b0;
      wr_buf     <= 1'b0;
      skip       <= 1'b0;
      bad        <= 1'b0;
      phase      <= 1'b0;
      href_q     <= 1'b0;
      byte0      <= '0;
      x          <= '0;
      y          <= '0;
      line_base  <= '0;
      rd_idx     <= 1'b0;
      frame_done <= 1'b0;
      frame_err  <= 1'b0;
      drop_cnt   <= '0;
      bram_addr  <= '0;
      bram_din   <= '0;
      bram_en    <= 1'b0;
      bram_we    <= 1'b0;
    end else begin
      enable_q   <= enable;
      frame_done <= 1'b0;
      bram_en    <= 1'b0;
      bram_we    <= 1'b0;
      if (enable && !enable_q) frame_err <= 1'b0;

      unique case (state)
        ST_IDLE: if (enable && cam_rst_n) state <= ST_WAIT_VS;

        ST_WAIT_VS: begin
          if (!enable) state <= ST_IDLE;
          else if (vsync_s) state <= ST_WAIT_FS;
        end

        ST_WAIT_FS: begin
          if (!enable) begin
            state <= ST_IDLE;
          end else if (vsync_fall_c) begin
            x         <= '0;
            y         <= '0;
            phase     <= 1'b0;
            href_q    <= 1'b0;
            bad       <= 1'b0;
            skip      <= (NUM_BUF == 1) && rd_lock;
            line_base <= wr_buf ? AWIDTH'(FRAME_PIX) : '0;
            state     <= ST_CAPTURE;
          end
        end

        ST_CAPTURE: begin
          if (pclk_rise_c) begin
            href_q <= href_s;
            if (href_s) begin
              phase <= ~phase;
              if (!phase) begin
                byte0 <= d_s2;
              end else begin
                if ((x < XW'(IMG_W)) && (y < YW'(IMG_H)) && !skip) begin
                  bram_en   <= 1'b1;
                  bram_we   <= 1'b1;
                  bram_addr <= line_base + AWIDTH'(x);
                  bram_din  <= pix_c;
                end
                if (x != XW'(IMG_W + 1)) x <= x + XW'(1);
              end
            end else if (href_q) begin
              // End of line: a dangling first byte is simply forgotten.
              phase     <= 1'b0;
              x         <= '0;
              line_base <= line_base + AWIDTH'(IMG_W);
              if (y != YW'(IMG_H + 1)) y <= y + YW'(1);
              if (x != XW'(IMG_W)) begin
                frame_err <= 1'b1;
                bad       <= 1'b1;
              end
            end
          end
          if (vsync_rise_c) state <= ST_PUBLISH;
        end

        ST_PUBLISH: begin
          if (!skip && !bad && (y == YW'(IMG_H))) begin
            rd_idx     <= wr_buf;
            frame_done <= 1'b1;
            if (!(rd_lock && (next_buf_c == rd_idx))) wr_buf <= next_buf_c;
          end else begin
            drop_cnt <= sat_inc8(drop_cnt);
          end
          if (!skip && (y < YW'(IMG_H))) frame_err <= 1'b1;
          state <= enable ? ST_WAIT_FS : ST_IDLE;
        end

        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule
